// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART echo responder.
// Counters are CNT_W wide and saturate rather than wrap.
package uart_pkg;
  localparam int BYTE_W = 8;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, GAP} state_t;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction
endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous FIFO, head combinational from storage; push lands at head next cycle.
// Push is accepted when not full or popping the same cycle; pop is ignored when empty.
module uart_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/uart_echo_responder.sv
// Buffers received bytes and replays them to the transmitter; rx_done at N gives tx_start at N+2.
// Holds off while tx_busy or disabled; drops bytes into overflow_cnt when the FIFO is full.
module uart_echo_responder
  import uart_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     enable,
  input  logic [BYTE_W-1:0]        rx_data,
  input  logic                     rx_done,
  input  logic                     rx_error,
  input  logic                     tx_busy,
  input  logic                     tx_done,
  output logic                     tx_start,
  output logic [BYTE_W-1:0]        tx_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         overflow_cnt,
  output logic [CNT_W-1:0]         err_cnt
);
  localparam int TMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES);

  state_t            state;
  logic [TW-1:0]     timer;
  logic [BYTE_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              rx_ok;
  logic              pop;
  logic              push;
  logic              timeout_hit;
  logic              drop;
  logic              rx_bad;

  assign rx_ok       = rx_done && !rx_error;
  assign rx_bad      = rx_done && rx_error;
  assign pop         = (state == SEND);
  assign push        = rx_ok && (!fifo_full || pop);
  assign drop        = rx_ok && fifo_full && !pop;
  // A tx_done arriving on the last timeout cycle still counts as a completion.
  assign timeout_hit = (state == WAIT_DONE) && !tx_done && (timer == TO_LAST);

  uart_byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .wdata (rx_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_cnt <= '0;
      err_cnt      <= '0;
    end else begin
      overflow_cnt <= sat_add(overflow_cnt, {1'b0, drop});
      err_cnt      <= sat_add(err_cnt, {1'b0, rx_bad} + {1'b0, timeout_hit});
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      timer    <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_start <= 1'b0;
          if (enable && !fifo_empty && !tx_busy) begin
            state    <= SEND;
            tx_start <= 1'b1;
            tx_data  <= fifo_rdata;
          end
        end
        SEND: begin
          tx_start <= 1'b0;
          timer    <= '0;
          state    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done || timeout_hit) begin
            timer <= '0;
            state <= GAP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        GAP: begin
          if (timer == GAP_LAST) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          tx_start <= 1'b0;
          timer    <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_echo_responder.sv
// Self-checking bench for uart_echo_responder with a scoreboard of expected echoed bytes.
module tb_uart_echo_responder;
  localparam int DEPTH   = 8;
  localparam int GAP     = 16;
  localparam int TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       rx_error = 1'b0;
  logic       tx_busy = 1'b0;
  logic       tx_done = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] fifo_count;
  logic [7:0] overflow_cnt;
  logic [7:0] err_cnt;

  uart_echo_responder #(
    .DEPTH          (DEPTH),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .enable       (enable),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .rx_error     (rx_error),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .fifo_count   (fifo_count),
    .overflow_cnt (overflow_cnt),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_done_cyc = -1;
  bit         tx_never = 1'b0;
  logic [7:0] exp_q[$];
  int         exp_ovf = 0;
  int         exp_err = 0;

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic [3:0] exp_count;
    logic [7:0] exp_err;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: every tx_start must carry the oldest outstanding expected byte.
  always @(negedge clk) begin
    if (rstn && tx_start) begin
      if (exp_q.size() == 0) begin
        check("tx_start_unexpected", tx_start, 0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("tx_data", tx_data, e);
      end
      if (last_done_cyc >= 0) check("gap_after_done", (cyc - last_done_cyc) > GAP, 1);
    end
  end

  // Transmitter model: busy for 10 clocks after tx_start, then tx_done unless muted.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && tx_start) begin
        tx_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (!rstn) break;
        end
        if (rstn && !tx_never) begin
          tx_done = 1'b1;
          last_done_cyc = cyc;
        end
        tx_busy = 1'b0;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  task automatic send_rx(input logic [7:0] d, input logic e);
    @(negedge clk);
    rx_data  = d;
    rx_done  = 1'b1;
    rx_error = e;
    @(negedge clk);
    rx_done  = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic wait_tx_start(input int max_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_start && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("tx_start_seen", tx_start, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_busy || fifo_count != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (40) @(negedge clk);
    check("drain_scoreboard_empty", exp_q.size(), 0);
    check("drain_fifo_count", fifo_count, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'h55, 1'b0, 4'd1, 8'd0};
    tbl[1] = '{8'hAA, 1'b0, 4'd2, 8'd0};
    tbl[2] = '{8'h3C, 1'b1, 4'd2, 8'd1};
    tbl[3] = '{8'h00, 1'b0, 4'd3, 8'd1};
    tbl[4] = '{8'hFF, 1'b0, 4'd4, 8'd1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow_cnt", overflow_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Latency: rx_done at N -> count 1 at N+1 -> tx_start at N+2
    enable = 1'b1;
    exp_q.push_back(8'h5A);
    send_rx(8'h5A, 1'b0);
    check("lat_count_n1", fifo_count, 1);
    check("lat_no_start_n1", tx_start, 0);
    @(negedge clk);
    check("lat_start_n2", tx_start, 1);
    check("lat_data_n2", tx_data, 8'h5A);
    drain();

    // Table: buffer with replay disabled, including a framing error
    enable = 1'b0;
    foreach (tbl[i]) begin
      if (!tbl[i].err) exp_q.push_back(tbl[i].data);
      send_rx(tbl[i].data, tbl[i].err);
      check($sformatf("tbl%0d_fifo_count", i), fifo_count, tbl[i].exp_count);
      check($sformatf("tbl%0d_err_cnt", i), err_cnt, tbl[i].exp_err);
      check($sformatf("tbl%0d_no_start", i), tx_start, 0);
    end
    exp_err = 1;
    enable = 1'b1;
    drain();

    // Overflow: 10 bytes into an 8-deep FIFO
    enable = 1'b0;
    begin
      int model_cnt;
      model_cnt = 0;
      for (int i = 1; i <= 10; i++) begin
        if (model_cnt < DEPTH) begin
          exp_q.push_back(8'(i));
          model_cnt++;
        end else begin
          exp_ovf++;
        end
        send_rx(8'(i), 1'b0);
      end
    end
    check("ovf_fifo_count", fifo_count, DEPTH);
    check("ovf_overflow_cnt", overflow_cnt, exp_ovf);
    enable = 1'b1;
    drain();

    // Push while full in the same cycle as the SEND pop
    enable = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(8'h80 + 8'(i));
      send_rx(8'h80 + 8'(i), 1'b0);
    end
    check("full_fifo_count", fifo_count, DEPTH);
    enable = 1'b1;
    wait_tx_start(5);
    rx_data = 8'h88;
    rx_done = 1'b1;
    exp_q.push_back(8'h88);
    @(negedge clk);
    rx_done = 1'b0;
    check("pushpop_fifo_count", fifo_count, DEPTH);
    check("pushpop_overflow_cnt", overflow_cnt, exp_ovf);
    drain();

    // Timeout: transmitter never reports done
    tx_never = 1'b1;
    enable = 1'b0;
    exp_q.push_back(8'h11);
    send_rx(8'h11, 1'b0);
    exp_q.push_back(8'h22);
    send_rx(8'h22, 1'b0);
    enable = 1'b1;
    wait_tx_start(5);
    repeat (TIMEOUT) @(negedge clk);
    check("to_err_before", err_cnt, exp_err);
    @(negedge clk);
    exp_err++;
    check("to_err_after", err_cnt, exp_err);
    wait_tx_start(200);
    repeat (TIMEOUT + 1) @(negedge clk);
    exp_err++;
    check("to2_err_after", err_cnt, exp_err);
    check("to_fifo_count", fifo_count, 0);
    tx_never = 1'b0;
    repeat (30) @(negedge clk);

    // Reset while in WAIT_DONE with 3 bytes still queued
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'hA1 + 8'(i));
      send_rx(8'hA1 + 8'(i), 1'b0);
    end
    enable = 1'b1;
    wait_tx_start(5);
    repeat (3) @(negedge clk);
    check("pre_rst_fifo_count", fifo_count, 3);
    rstn = 1'b0;
    #1;
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_fifo_count", fifo_count, 0);
    check("mid_rst_overflow_cnt", overflow_cnt, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    exp_q.delete();
    exp_ovf = 0;
    exp_err = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (60) @(negedge clk);
    check("post_rst_fifo_count", fifo_count, 0);
    check("post_rst_err_cnt", err_cnt, exp_err);
    exp_q.push_back(8'hC3);
    send_rx(8'hC3, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_echo_responder.md
Name: uart_echo_responder

Overview:
- User-side responder for uart_transceiver's parallel byte interface.
- Consumes received bytes (rx_data/rx_done) and buffers them in a small FIFO.
- Replays each byte to the transmit side (tx_start/tx_data), obeying tx_busy/tx_done.
- Provides board-level loopback and serves as the far end of the transmit handshake in system tests.

Parameters:
- DEPTH, 8, FIFO depth in bytes; power of 2, >= 2.
- GAP_CYCLES, 16, idle clocks inserted after each tx_done before the next tx_start; 0 allowed.
- TIMEOUT_CYCLES, 1_000_000, max clocks from tx_start to tx_done before the byte is abandoned.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- enable  input  1  1 = replay buffered bytes; 0 = keep buffering, issue no new tx_start.
- rx_data  input  8  received byte from transceiver.
- rx_done  input  1  one-cycle pulse; rx_data valid this cycle.
- rx_error  input  1  framing error; qualifies rx_done in the same cycle.
- tx_busy  input  1  transmitter busy.
- tx_done  input  1  one-cycle pulse at end of stop bit.
- tx_start  output  1  one-cycle transmit request.
- tx_data  output  8  byte to transmit; held stable from tx_start until tx_done or timeout.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.
- overflow_cnt  output  8  bytes dropped because FIFO full; saturates at 255.
- err_cnt  output  8  rx_done with rx_error plus tx timeouts; saturates at 255.

Behaviour:
- Reset (async assert, sync deassert in the clk domain): tx_start=0, tx_data=8'h00, fifo_count=0, overflow_cnt=0, err_cnt=0, FSM=IDLE. FIFO contents are discarded.
- Push: rx_done=1 && rx_error=0 && (not full || pop this cycle).
- Byte is visible at the FIFO head the cycle after push.
- rx_done=1 && rx_error=1: byte discarded, err_cnt+1.
- rx_done while full with no same-cycle pop: byte dropped, overflow_cnt+1.
- Push and pop in the same cycle: both happen; fifo_count unchanged. When empty, no bypass: pop is impossible, so count becomes 1.
- FIFO pointers wrap modulo DEPTH. Full = count==DEPTH.
- FSM states: IDLE, SEND, WAIT_DONE, GAP.
  - IDLE -> SEND when enable && count>0 && !tx_busy.
  - SEND (one cycle): tx_data<=head, tx_start=1 for exactly one cycle, pop. -> WAIT_DONE.
  - WAIT_DONE: timeout counter runs. On tx_done -> GAP. On count reaching TIMEOUT_CYCLES: err_cnt+1, byte abandoned (not re-queued) -> GAP.
  - GAP: counts GAP_CYCLES clocks, then -> IDLE. GAP_CYCLES=0 means a single-cycle pass through GAP.
- A tx_done pulse seen outside WAIT_DONE is ignored.
- Deasserting enable mid-byte does not abort it; the current byte completes normally.
- Latency, ignoring gap and busy: rx_done at cycle N -> FIFO non-empty at N+1 -> SEND at N+2 -> tx_start high at N+2 (registered output, visible during cycle N+2).
- Simultaneous err_cnt events (rx_error and timeout in the same cycle): increment by 2, saturating.
- Reset mid-transfer: tx_start=0 immediately. The transceiver's own reset handles its line state.

Decomposition:
- Package uart_pkg:
  - FSM state enum (IDLE, SEND, WAIT_DONE, GAP).
  - BYTE_W=8.
  - CNT_W=8, plus a saturating-increment function.
- Sub-module uart_byte_fifo:
  - Synchronous FIFO with params DEPTH, WIDTH.
  - Ports: push, pop, wdata, rdata (head, combinational from registered storage), full, empty, count.
  - Same clk/rstn.

Test Plan:
- Basic echo: enable=1; pulse rx_done with 8'h55, then 8'hAA, 8'h00, 8'hFF, transmitter model returning tx_done 10 clocks after tx_start -> four tx_start pulses with tx_data 55, AA, 00, FF in order; ≥GAP_CYCLES idle clocks between tx_done and the next tx_start; fifo_count returns to 0.
- Overflow: enable=0, DEPTH=8, push 10 bytes 8'h01..8'h0A -> fifo_count=8, overflow_cnt=2. Then enable=1 -> bytes 01..08 transmitted only.
- Simultaneous push/pop at full: FIFO full, rx_done in the same cycle as SEND pop -> byte accepted, overflow_cnt unchanged, fifo_count stays 8.
- Framing error: rx_done with rx_error=1 and rx_data=8'h3C -> no push, no tx_start, err_cnt=1.
- Timeout: TIMEOUT_CYCLES=100, transmitter model never pulses tx_done -> after 100 clocks in WAIT_DONE, err_cnt+1. Next queued byte is then sent after GAP.
- Reset mid-operation: assert rstn=0 while in WAIT_DONE with 3 bytes queued -> tx_start=0, fifo_count=0, counters=0 immediately. After release, no tx_start until a new rx_done.
